uart_rx_deserializer: RTL and testbench
=======================================

Name: uart_rx_deserializer

Overview:
UART receive path. It is the counterpart of the TX serializer.
- Detects the start bit on the serial line and oversamples each bit by OVERSAMPLE.
- Majority-votes three mid-bit samples, shifts data in LSB first, and optionally checks parity.
- Checks the stop bit and presents the received byte with a one-cycle valid pulse or an error pulse.
- Sits between the RX pad and the system-side register/FIFO logic.

Parameters:
DATA_WIDTH, 8, bits per frame payload
OVERSAMPLE, 8, clocks per serial bit; must be even and >= 4

Ports:
CLK  input  1  system clock, single clock domain
RST  input  1  asynchronous, active-high reset
RX_IN  input  1  serial line; idles high
PAR_EN  input  1  1 = frame carries a parity bit after the data
PAR_TYP  input  1  0 = even parity, 1 = odd parity
P_DATA  output  DATA_WIDTH  last good received word
data_valid  output  1  one-cycle pulse: P_DATA updated with a good frame
par_err  output  1  one-cycle pulse: frame ended with a parity mismatch
stp_err  output  1  one-cycle pulse: stop bit sampled low

Behaviour:
- Reset (async, RST=1):
  - State goes to IDLE; all counters are cleared.
  - P_DATA=0; data_valid=0, par_err=0, stp_err=0.
  - Asserting RST mid-frame aborts the frame with no pulses. Reception restarts from IDLE after release.
- Counters:
  - edge_cnt runs 0..OVERSAMPLE-1 within a bit. At OVERSAMPLE-1 it wraps to 0 and bit_cnt advances.
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
- Sampling:
  - Samples are taken at edge_cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The bit value is the majority of the 3 samples. It is valid from edge_cnt = OVERSAMPLE/2+2 onward.
- States:
  - IDLE: if RX_IN=0 at a clock edge, go to START with edge_cnt=0. That cycle is sample slot 0 of the start bit. PAR_EN and PAR_TYP are latched here for the whole frame.
  - START: if the voted start bit is 1 (glitch), return to IDLE immediately after the vote, with no pulses. Otherwise go to DATA at the end of the bit.
  - DATA: the voted bit is shifted into the shift register MSB-side, so the first received bit ends up in bit 0 (LSB first). After DATA_WIDTH bits, go to PARITY if the latched PAR_EN=1, else to STOP.
  - PARITY: compare the voted bit with the XOR of the data, inverted when PAR_TYP=1. A mismatch sets an internal parity-fail flag. At the end of the bit, go to STOP.
  - STOP: if the voted bit is 0, set an internal stop-fail flag. On the last clock of the bit (edge_cnt = OVERSAMPLE-1), return to IDLE and register the result.
- Result (registered on the transition STOP→IDLE, each output high for exactly one cycle):
  - No failure: P_DATA <= shift register, data_valid=1.
  - Parity failure: par_err=1; P_DATA is unchanged.
  - Stop failure: stp_err=1; P_DATA is unchanged.
  - Both failures: par_err=1 and stp_err=1 in the same cycle; data_valid=0.
- Latency:
  - The result pulse is high (2+DATA_WIDTH+PAR_EN)*OVERSAMPLE cycles after the IDLE start-detect edge.
  - This is 80 cycles for 8N1 at OVERSAMPLE=8, and 88 with parity.
- Back-to-back frames: in the cycle the result pulse is high, the block is already in IDLE. A low RX_IN in that cycle starts the next frame, so no gap cycles are required.
- Changing PAR_EN or PAR_TYP mid-frame has no effect until the next start detect.
- A break condition (RX_IN held low) gives stp_err for each frame time. After each one the block re-enters START while the line stays low.

Optional Feature:
Macro: UART_RX_SYNC_EN.
- Defined: RX_IN passes through a 2-flop synchronizer, reset to 1, before the start detector and sampler. All latencies grow by 2 cycles; 8N1 at OVERSAMPLE=8 gives 82 cycles.
- Undefined: RX_IN is used directly. The line must already be synchronous to CLK.

Test Plan:
- Reset, then 8N1 frame 0xA5 at OVERSAMPLE=8 (bits 1,0,1,0,0,1,0,1 after the start bit, then stop 1) -> P_DATA=0xA5; data_valid high for exactly 1 cycle, 80 cycles after the start edge; par_err=0, stp_err=0.
- PAR_EN=1, PAR_TYP=0, data 0x3C with parity bit 0, then the same data with parity bit 1 -> first frame: data_valid, P_DATA=0x3C. Second frame: par_err pulse at cycle 88, P_DATA stays 0x3C.
- Frame 0x55 with the stop bit driven 0 -> stp_err pulse; data_valid=0; P_DATA keeps its previous value.
- RX_IN low for 2 cycles, then high -> start glitch rejected; no pulses; a following valid 0x81 frame is received correctly.
- Two frames 0x12 then 0xEF, the second start bit beginning in the same cycle as the first data_valid -> both received, with data_valid pulses exactly 80 cycles apart.
- RST asserted at cycle 40 of a frame and released 3 cycles later, then a clean 0x7E frame -> no pulse for the aborted frame; P_DATA=0 until the 0x7E data_valid; repeat with UART_RX_SYNC_EN defined, expecting an 82-cycle latency.

Source files
------------

// File: rtl/uart_rx_deserializer_if.sv
// Serial-in / word-out bundle between the RX pad side and the system-side UART receiver.
// master drives the line and frame format; slave (the deserializer) returns the word and result pulses.
interface uart_rx_deserializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP,
    input  P_DATA, data_valid, par_err, stp_err
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP,
    output P_DATA, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART RX: start detect, 3-sample mid-bit majority vote, LSB-first shift, optional parity, stop check.
// Result pulse (2+DATA_WIDTH+PAR_EN)*OVERSAMPLE cycles after the line falls, no backpressure; UART_RX_SYNC_EN adds a 2-flop RX synchronizer (+2).
module uart_rx_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  uart_rx_deserializer_if.slave bus
);

  localparam int EW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [EW-1:0] EC_ONE   = EW'(1);
  localparam logic [EW-1:0] EC_SAMP0 = EW'(OVERSAMPLE / 2 - 1);
  localparam logic [EW-1:0] EC_SAMP1 = EW'(OVERSAMPLE / 2);
  localparam logic [EW-1:0] EC_SAMP2 = EW'(OVERSAMPLE / 2 + 1);
  localparam logic [EW-1:0] EC_LAST  = EW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BC_ONE   = BW'(1);
  localparam logic [BW-1:0] BC_LAST  = BW'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic w_rx;

`ifdef UART_RX_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], bus.RX_IN};
    end
  end

  assign w_rx = r_sync[1];
`else
  assign w_rx = bus.RX_IN;
`endif

  logic [2:0]            r_state;
  logic [EW-1:0]         r_edge_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic [1:0]            r_samp;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_fail;
  logic                  r_stp_fail;
  logic                  r_dv;
  logic                  r_pe;
  logic                  r_se;

  logic                  w_vote;
  logic                  w_at_vote;
  logic                  w_bit_end;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic                  w_par_exp;
  logic                  w_stp_bad;

  // Third sample is the live line, so the vote is usable on the edge that ends slot OVERSAMPLE/2+1.
  always_comb begin
    w_vote      = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rx) | (r_samp[1] & w_rx);
    w_at_vote   = (r_edge_cnt == EC_SAMP2);
    w_bit_end   = (r_edge_cnt == EC_LAST);
    w_shift_nxt = r_shift >> 1;
    w_shift_nxt[DATA_WIDTH-1] = w_vote;
    w_par_exp   = (^r_shift) ^ r_par_typ;
    w_stp_bad   = r_stp_fail | (w_at_vote & ~w_vote);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_samp     <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_par_fail <= 1'b0;
      r_stp_fail <= 1'b0;
      r_dv       <= 1'b0;
      r_pe       <= 1'b0;
      r_se       <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      r_pe <= 1'b0;
      r_se <= 1'b0;

      if (r_edge_cnt == EC_SAMP0) r_samp[0] <= w_rx;
      if (r_edge_cnt == EC_SAMP1) r_samp[1] <= w_rx;

      if (r_state != S_IDLE) begin
        r_edge_cnt <= w_bit_end ? '0 : r_edge_cnt + EC_ONE;
      end

      case (r_state)
        S_IDLE: begin
          // The detect cycle itself is slot 0 of the start bit, so the counter resumes at 1.
          if (!w_rx) begin
            r_state    <= S_START;
            r_edge_cnt <= EC_ONE;
            r_bit_cnt  <= '0;
            r_par_en   <= bus.PAR_EN;
            r_par_typ  <= bus.PAR_TYP;
            r_par_fail <= 1'b0;
            r_stp_fail <= 1'b0;
          end
        end

        S_START: begin
          if (w_at_vote && w_vote) begin
            r_state    <= S_IDLE;
            r_edge_cnt <= '0;
          end else if (w_bit_end) begin
            r_state <= S_DATA;
          end
        end

        S_DATA: begin
          if (w_at_vote) r_shift <= w_shift_nxt;
          if (w_bit_end) begin
            if (r_bit_cnt == BC_LAST) begin
              r_state <= r_par_en ? S_PARITY : S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + BC_ONE;
            end
          end
        end

        S_PARITY: begin
          if (w_at_vote && (w_vote != w_par_exp)) r_par_fail <= 1'b1;
          if (w_bit_end) r_state <= S_STOP;
        end

        S_STOP: begin
          if (w_at_vote && !w_vote) r_stp_fail <= 1'b1;
          if (w_bit_end) begin
            r_state <= S_IDLE;
            r_pe    <= r_par_fail;
            r_se    <= w_stp_bad;
            if (!r_par_fail && !w_stp_bad) begin
              r_data <= r_shift;
              r_dv   <= 1'b1;
            end
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_edge_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.P_DATA     = r_data;
  assign bus.data_valid = r_dv;
  assign bus.par_err    = r_pe;
  assign bus.stp_err    = r_se;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: hand-built frames, pulse counts, data and latency checks.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;

  localparam int DW = 8;
  localparam int OS = 8;
`ifdef UART_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int LAT_8N1 = 80 + SYNC_LAT;
  localparam int LAT_8P1 = 88 + SYNC_LAT;

  logic CLK;
  logic RST;

  uart_rx_deserializer_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx_deserializer #(
    .DATA_WIDTH(DW),
    .OVERSAMPLE(OS)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int n_dv, n_pe, n_se, n_both;
  int dv0_cyc, dv1_cyc, dv0_dat, dv1_dat, pe_cyc, se_cyc;
  int frame_start;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Pulse monitor: counts high cycles so a stretched pulse shows up as a count above one.
  initial forever begin
    @(negedge CLK);
    if (bus.data_valid === 1'b1) begin
      if (n_dv == 0) begin dv0_cyc = cyc; dv0_dat = int'(bus.P_DATA); end
      if (n_dv == 1) begin dv1_cyc = cyc; dv1_dat = int'(bus.P_DATA); end
      n_dv++;
    end
    if (bus.par_err === 1'b1) begin n_pe++; pe_cyc = cyc; end
    if (bus.stp_err === 1'b1) begin n_se++; se_cyc = cyc; end
    if (bus.par_err === 1'b1 && bus.stp_err === 1'b1) n_both++;
  end

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  task automatic clr();
    n_dv = 0; n_pe = 0; n_se = 0; n_both = 0;
    dv0_cyc = -1; dv1_cyc = -1; dv0_dat = -1; dv1_dat = -1;
    pe_cyc = -1; se_cyc = -1;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    bus.RX_IN = b;
    step(OS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic par, input logic stop);
    frame_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (has_par) drive_bit(par);
    drive_bit(stop);
    bus.RX_IN = 1'b1;
  endtask

  initial begin
    int s0;
    bus.RX_IN = 1'b1; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
    RST = 1'b1;
    clr();
    step(3);
    check("rst_pdata", int'(bus.P_DATA), 0);
    check("rst_dv", int'(bus.data_valid), 0);
    check("rst_pe", int'(bus.par_err), 0);
    check("rst_se", int'(bus.stp_err), 0);
    RST = 1'b0;
    step(5);

    // 8N1 0xA5
    clr();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    step(4);
    check("a5_dv_cnt", n_dv, 1);
    check("a5_lat", dv0_cyc - frame_start, LAT_8N1);
    check("a5_data", dv0_dat, 8'hA5);
    check("a5_pdata", int'(bus.P_DATA), 8'hA5);
    check("a5_pe", n_pe, 0);
    check("a5_se", n_se, 0);

    // Even parity: 0x3C has four ones -> parity bit 0 is good, 1 is bad
    bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0;
    clr();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    step(4);
    check("pev_dv_cnt", n_dv, 1);
    check("pev_lat", dv0_cyc - frame_start, LAT_8P1);
    check("pev_data", int'(bus.P_DATA), 8'h3C);
    clr();
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    step(4);
    check("pbad_pe_cnt", n_pe, 1);
    check("pbad_lat", pe_cyc - frame_start, LAT_8P1);
    check("pbad_dv", n_dv, 0);
    check("pbad_pdata", int'(bus.P_DATA), 8'h3C);

    // Odd parity: 0x3C needs 1, 0x07 (three ones) needs 0
    bus.PAR_TYP = 1'b1;
    clr();
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    step(4);
    check("podd1_dv", n_dv, 1);
    check("podd1_pe", n_pe, 0);
    clr();
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    step(4);
    check("podd2_dv", n_dv, 1);
    check("podd2_pdata", int'(bus.P_DATA), 8'h07);

    // Parity and stop both bad in one frame
    bus.PAR_TYP = 1'b0;
    clr();
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    step(4);
    check("both_pe", n_pe, 1);
    check("both_se", n_se, 1);
    check("both_same_cyc", n_both, 1);
    check("both_dv", n_dv, 0);
    check("both_pdata", int'(bus.P_DATA), 8'h07);
    bus.PAR_EN = 1'b0;

    // Stop bit low
    clr();
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    step(4);
    check("stp_se", n_se, 1);
    check("stp_lat", se_cyc - frame_start, LAT_8N1);
    check("stp_dv", n_dv, 0);
    check("stp_pdata", int'(bus.P_DATA), 8'h07);

    // Two-cycle start glitch, then a clean 0x81
    clr();
    bus.RX_IN = 1'b0;
    step(2);
    bus.RX_IN = 1'b1;
    step(20);
    check("glitch_dv", n_dv, 0);
    check("glitch_pe", n_pe, 0);
    check("glitch_se", n_se, 0);
    clr();
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    step(4);
    check("g81_dv", n_dv, 1);
    check("g81_data", dv0_dat, 8'h81);

    // Break: two frame times of low line
    clr();
    bus.RX_IN = 1'b0;
    step(160);
    bus.RX_IN = 1'b1;
    step(20);
    check("brk_se", n_se, 2);
    check("brk_dv", n_dv, 0);
    check("brk_pdata", int'(bus.P_DATA), 8'h81);

    // Frame format changed mid-frame is ignored
    clr();
    fork
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
      begin
        step(20);
        bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b1;
      end
    join
    bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
    step(4);
    check("cfg_dv", n_dv, 1);
    check("cfg_lat", dv0_cyc - frame_start, LAT_8N1);
    check("cfg_pe", n_pe, 0);
    check("cfg_pdata", int'(bus.P_DATA), 8'h5A);

    // Back-to-back 0x12 then 0xEF with no gap
    clr();
    send_frame(8'h12, 1'b0, 1'b0, 1'b1);
    s0 = frame_start;
    send_frame(8'hEF, 1'b0, 1'b0, 1'b1);
    step(4);
    check("b2b_dv_cnt", n_dv, 2);
    check("b2b_data0", dv0_dat, 8'h12);
    check("b2b_data1", dv1_dat, 8'hEF);
    check("b2b_lat0", dv0_cyc - s0, LAT_8N1);
    check("b2b_gap", dv1_cyc - dv0_cyc, 80);

    // Reset 40 cycles into a frame, then a clean 0x7E
    clr();
    frame_start = cyc;
    drive_bit(1'b0);
    drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b0);
    RST = 1'b1;
    bus.RX_IN = 1'b1;
    step(3);
    RST = 1'b0;
    step(100);
    check("abort_dv", n_dv, 0);
    check("abort_pe", n_pe, 0);
    check("abort_se", n_se, 0);
    check("abort_pdata", int'(bus.P_DATA), 0);
    clr();
    send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
    step(4);
    check("r7e_dv", n_dv, 1);
    check("r7e_lat", dv0_cyc - frame_start, LAT_8N1);
    check("r7e_pdata", int'(bus.P_DATA), 8'h7E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
